// File: rtl/cc_decoder.sv
// ---------------------------------------------------------------------------
// cc_decoder
//
// Serial decoder that undoes the normalize / shift / complement transforms of
// the upstream digit-transform block. A frame is one key digit followed by
// four encoded digits on the input port; the four reconstructed decimal
// digits are then returned on the output port, which honours back-pressure.
// Frames do not overlap: the input side is closed while a frame is decoded
// and emitted.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  input beat valid
//   in_ready   out  1  decoder accepts an input beat (KEY and DIG states)
//   in_mode    in   2  transform mode, sampled on the key beat only
//   in_digit   in   4  key digit, then encoded digits d0..d3
//   out_valid  out  1  output beat valid
//   out_ready  in   1  downstream accepts the output beat
//   out_digit  out  4  decoded digit, 0 while out_valid is low
//   out_err    out  1  frame error flag, 0 while out_valid is low
// ---------------------------------------------------------------------------
module cc_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_mode,
    input  logic [3:0] in_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_DIG,
        S_CALC,
        S_OUT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] key_q, key_d;
    logic [1:0] mode_q, mode_d;
    logic       err_q, err_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] ocnt_q, ocnt_d;
    logic [3:0] dig_q [4];
    logic [3:0] dig_d [4];
    logic [3:0] nbuf_q [4];
    logic [3:0] nbuf_d [4];

    logic       digitBad;
    logic [3:0] digitClean;

    // (a + b) mod 10 for two legal digits: 5-bit add, one conditional subtract.
    function automatic logic [3:0] addMod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    // Ten's complement of a single digit, with 0 mapping to itself.
    function automatic logic [3:0] compl10(input logic [3:0] d);
        return (d == 4'd0) ? 4'd0 : (4'd10 - d);
    endfunction

    // Illegal digits are flagged and replaced by 0 before any arithmetic.
    assign digitBad   = (in_digit >= 4'd10);
    assign digitClean = digitBad ? 4'd0 : in_digit;

    // Next-state and output decode; handshakes are pure functions of state so
    // every output collapses to 0 the instant reset is applied.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        mode_d    = mode_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ocnt_d    = ocnt_q;
        dig_d     = dig_q;
        nbuf_d    = nbuf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_digit = 4'd0;
        out_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_KEY;
            end

            S_KEY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    key_d   = digitClean;
                    mode_d  = in_mode;
                    err_d   = digitBad;
                    cnt_d   = 2'd0;
                    state_d = S_DIG;
                end
            end

            S_DIG: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dig_d[cnt_q] = digitClean;
                    err_d        = err_q | digitBad;
                    cnt_d        = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                case (mode_q)
                    2'd0: begin
                        nbuf_d = dig_q;
                    end
                    2'd1: begin
                        for (int i = 0; i < 4; i++) begin
                            nbuf_d[i] = addMod10(dig_q[i], key_q);
                        end
                    end
                    2'd2: begin
                        // d0 is the slot the shift pushed in; the key itself is n3.
                        nbuf_d[0] = addMod10(dig_q[3], key_q);
                        nbuf_d[1] = addMod10(dig_q[2], key_q);
                        nbuf_d[2] = addMod10(dig_q[1], key_q);
                        nbuf_d[3] = key_q;
                    end
                    default: begin
                        for (int i = 0; i < 4; i++) begin
                            nbuf_d[i] = compl10(dig_q[i]);
                        end
                    end
                endcase
                if ((mode_q == 2'd1 || mode_q == 2'd2) && dig_q[0] != 4'd0) begin
                    err_d = 1'b1;
                end
                ocnt_d  = 2'd0;
                state_d = S_OUT;
            end

            S_OUT: begin
                out_valid = 1'b1;
                out_digit = nbuf_q[ocnt_q];
                out_err   = err_q;
                if (out_ready) begin
                    ocnt_d = ocnt_q + 2'd1;
                    if (ocnt_q == 2'd3) begin
                        state_d = S_KEY;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= 4'd0;
            mode_q  <= 2'd0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
            ocnt_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i]  <= 4'd0;
                nbuf_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            dig_q   <= dig_d;
            nbuf_q  <= nbuf_d;
        end
    end

endmodule

// File: tb/tb_cc_decoder.sv
// ---------------------------------------------------------------------------
// tb_cc_decoder
//
// Directed bench for cc_decoder. Frames are decoded by an arithmetic model
// into a queue of expected {err, digit} beats; a negedge monitor checks every
// output cycle against the queue head. Literal expectations pin the model and
// the handshake timing.
// ---------------------------------------------------------------------------
module tb_cc_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_mode;
    logic [3:0] in_digit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_err;

    int         compared;
    int         mismatched;
    logic [4:0] expQ [$];

    cc_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_err   (out_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by the monitor and the directed checks.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Decode rules in plain integer arithmetic.
    task automatic modelFrame(input int mode, input int key, input int d[4],
                              output int n[4], output int err);
        int k;
        int c[4];
        err = (key >= 10) ? 1 : 0;
        k   = (key >= 10) ? 0 : key;
        for (int i = 0; i < 4; i++) begin
            if (d[i] >= 10) begin
                err  = 1;
                c[i] = 0;
            end else begin
                c[i] = d[i];
            end
        end
        if ((mode == 1 || mode == 2) && c[0] != 0) err = 1;
        for (int i = 0; i < 4; i++) begin
            case (mode)
                0:       n[i] = c[i];
                1:       n[i] = (c[i] + k) % 10;
                2:       n[i] = (i == 3) ? k : (c[3 - i] + k) % 10;
                default: n[i] = (10 - c[i]) % 10;
            endcase
        end
    endtask

    // Check the model alone against hand-computed results.
    task automatic pinModel(input string name, input int mode, input int key,
                            input int a0, input int a1, input int a2, input int a3,
                            input int e0, input int e1, input int e2, input int e3,
                            input int eErr);
        int d[4];
        int n[4];
        int err;
        int e[4];
        d = '{a0, a1, a2, a3};
        e = '{e0, e1, e2, e3};
        modelFrame(mode, key, d, n, err);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_n%0d", name, i), n[i], e[i]);
        end
        checkOutput($sformatf("%s_err", name), err, eErr);
    endtask

    // Present one input beat and hold it until it is accepted (bounded).
    task automatic applyStimulus(input logic [1:0] mode, input int digit);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_digit = 4'(digit);
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) checkOutput("beatAcceptTimeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_digit = 4'd0;
    endtask

    // Send a whole frame, with optional idle gaps, then queue its expected beats.
    task automatic sendFrame(input int mode, input int key,
                             input int a0, input int a1, input int a2, input int a3,
                             input int maxGap);
        int d[4];
        int n[4];
        int err;
        d = '{a0, a1, a2, a3};
        applyStimulus(2'(mode), key);
        for (int i = 0; i < 4; i++) begin
            if (maxGap > 0) repeat ($urandom_range(0, maxGap)) @(posedge clk);
            #1;
            // in_mode on digit beats must be ignored, so drive something else.
            applyStimulus(2'(~mode), d[i]);
        end
        modelFrame(mode, key, d, n, err);
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({1'(err), 4'(n[i])});
        end
    endtask

    // Wait for all expected beats to drain and the input side to reopen.
    task automatic waitDrain();
        int c;
        c = 0;
        while ((expQ.size() != 0 || !in_ready) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 300) checkOutput("drainTimeout", 0, 1);
    endtask

    // Output monitor: every cycle, idle outputs must be 0 and valid beats must
    // match (and hold on) the head of the expected queue.
    always @(negedge clk) begin
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousBeat", 1, 0);
            end else begin
                checkOutput("outDigit", int'(out_digit), int'(expQ[0][3:0]));
                checkOutput("outErr", int'(out_err), int'(expQ[0][4]));
                if (out_ready) void'(expQ.pop_front());
            end
        end else begin
            checkOutput("idleOutputs", int'({out_err, out_digit}), 0);
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_mode    = 2'd0;
        in_digit   = 4'd0;
        out_ready  = 1'b1;

        // Reset state and IDLE-then-KEY start-up.
        #3;
        checkOutput("rstInReady", int'(in_ready), 0);
        checkOutput("rstOutValid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("idleInReady", int'(in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("keyInReady", int'(in_ready), 1);

        // Pin the model to hand-computed results.
        pinModel("pinM2", 2, 4, 0, 7, 3, 9, 3, 7, 1, 4, 0);
        pinModel("pinM1", 1, 2, 0, 1, 5, 7, 2, 3, 7, 9, 0);
        pinModel("pinM3", 3, 6, 0, 3, 9, 5, 0, 7, 1, 5, 0);
        pinModel("pinErrD0", 2, 1, 5, 0, 0, 0, 1, 1, 1, 1, 1);
        pinModel("pinErrBig", 0, 0, 12, 3, 4, 5, 0, 3, 4, 5, 1);
        pinModel("pinWrap2", 2, 9, 0, 1, 1, 1, 0, 0, 0, 9, 0);

        // Mode 2 with latency: CALC cycle after the last beat, then out_valid.
        sendFrame(2, 4, 0, 7, 3, 9, 0);
        checkOutput("calcOutValid", int'(out_valid), 0);
        checkOutput("calcInReady", int'(in_ready), 0);
        @(posedge clk);
        #1;
        checkOutput("firstOutValid", int'(out_valid), 1);
        checkOutput("firstOutDigit", int'(out_digit), 3);
        checkOutput("outInReady", int'(in_ready), 0);
        waitDrain();

        // Mode 1, mode 3, and the error frames followed by a clean one.
        sendFrame(1, 2, 0, 1, 5, 7, 0);
        waitDrain();
        sendFrame(3, 6, 0, 3, 9, 5, 0);
        waitDrain();
        sendFrame(2, 1, 5, 0, 0, 0, 0);
        waitDrain();
        sendFrame(0, 0, 12, 3, 4, 5, 0);
        waitDrain();
        sendFrame(0, 7, 1, 2, 3, 4, 0);
        waitDrain();

        // Back-pressure: stall for 3 cycles while beat 2 (value 7) is pending.
        out_ready = 1'b0;
        sendFrame(1, 2, 0, 1, 5, 7, 0);
        begin
            int c;
            c = 0;
            while (!out_valid && c < 20) begin
                @(posedge clk);
                #1;
                c++;
            end
            if (c >= 20) checkOutput("bpValidTimeout", 0, 1);
        end
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bpHoldValid", int'(out_valid), 1);
            checkOutput("bpHoldDigit", int'(out_digit), 7);
        end
        out_ready = 1'b1;
        waitDrain();

        // Random input gaps and wrap-around sums.
        sendFrame(2, 4, 0, 7, 3, 9, 3);
        waitDrain();
        sendFrame(1, 9, 0, 9, 9, 9, 2);
        waitDrain();
        sendFrame(2, 9, 0, 1, 1, 1, 0);
        waitDrain();

        // Reset after 3 input beats: partial frame vanishes, no stale beats.
        applyStimulus(2'd1, 3);
        applyStimulus(2'd0, 0);
        applyStimulus(2'd0, 5);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstInReady", int'(in_ready), 0);
        checkOutput("midRstOutValid", int'(out_valid), 0);
        checkOutput("midRstOutBus", int'({out_err, out_digit}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("postRstIdle", int'(in_ready), 0);
        sendFrame(0, 0, 1, 2, 3, 4, 0);
        waitDrain();

        checkOutput("leftoverBeats", expQ.size(), 0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
